// File: rtl/cyber_player_array.sv
// Multi-channel threshold game: each round compares every player value against Q and keeps per-channel scores.
// Define CYBER_TIE_WIN_EN to let a value equal to Q count as a win (default: strictly greater wins).
module cyber_player_array #(
  parameter int WIDTH      = 10,
  parameter int NCH        = 2,
  parameter int SCORE_W    = 3,
  parameter int WIN_TARGET = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     start,
  input  logic [WIDTH-1:0]         Q,
  input  logic [NCH*(WIDTH-1)-1:0] SW,
  output logic                     busy,
  output logic                     win_valid,
  output logic [NCH-1:0]           win,
  output logic [NCH*SCORE_W-1:0]   score,
  output logic                     game_over,
  output logic [NCH-1:0]           winner
);

  localparam int VW = WIDTH - 1;
  localparam logic [SCORE_W-1:0] TARGET = SCORE_W'(WIN_TARGET);

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    RESULT,
    OVER
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     q_lat;
  logic [NCH*VW-1:0]    sw_lat;
  logic [NCH-1:0]       cmp_vec;
  logic [NCH-1:0]       cmp_reg;
  logic                 sampled;
  logic [NCH*SCORE_W-1:0] score_next;
  logic [NCH-1:0]       winner_next;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [WIDTH-1:0]   ext;
    logic [SCORE_W-1:0] cur;
    logic [SCORE_W-1:0] nxt;

    assign ext = {1'b0, sw_lat[i*VW +: VW]};
`ifdef CYBER_TIE_WIN_EN
    assign cmp_vec[i] = (ext >= q_lat);
`else
    assign cmp_vec[i] = (ext > q_lat);
`endif
    assign cur = score[i*SCORE_W +: SCORE_W];
    assign nxt = (cmp_reg[i] && (cur < TARGET)) ? cur + SCORE_W'(1) : cur;
    assign score_next[i*SCORE_W +: SCORE_W] = nxt;
    assign winner_next[i] = (nxt == TARGET);
  end

  assign busy = (state != IDLE);

  // SAMPLE spans two cycles: the first registers the compare, the second commits the result,
  // so the win_valid strobe and the updated score appear together while in RESULT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      q_lat     <= '0;
      sw_lat    <= '0;
      cmp_reg   <= '0;
      sampled   <= 1'b0;
      win_valid <= 1'b0;
      win       <= '0;
      score     <= '0;
      game_over <= 1'b0;
      winner    <= '0;
    end else if (clear) begin
      state     <= IDLE;
      cmp_reg   <= '0;
      sampled   <= 1'b0;
      win_valid <= 1'b0;
      win       <= '0;
      score     <= '0;
      game_over <= 1'b0;
      winner    <= '0;
    end else begin
      case (state)
        IDLE: begin
          win_valid <= 1'b0;
          sampled   <= 1'b0;
          if (start) begin
            q_lat  <= Q;
            sw_lat <= SW;
            state  <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (!sampled) begin
            cmp_reg <= cmp_vec;
            sampled <= 1'b1;
          end else begin
            win_valid <= 1'b1;
            win       <= cmp_reg;
            score     <= score_next;
            winner    <= winner_next;
            state     <= RESULT;
          end
        end
        RESULT: begin
          win_valid <= 1'b0;
          sampled   <= 1'b0;
          if (|winner) begin
            game_over <= 1'b1;
            state     <= OVER;
          end else begin
            state <= IDLE;
          end
        end
        OVER: begin
          win_valid <= 1'b0;
          game_over <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          win_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cyber_player_array.sv
// Directed scoreboard bench for cyber_player_array; expected round results are queued at start and
// popped when win_valid fires. Honours CYBER_TIE_WIN_EN in its reference model.
module tb_cyber_player_array;

  localparam int WIDTH      = 10;
  localparam int NCH        = 2;
  localparam int SCORE_W    = 3;
  localparam int WIN_TARGET = 7;
  localparam int VW         = WIDTH - 1;

  logic                     clk   = 1'b0;
  logic                     reset = 1'b0;
  logic                     clear = 1'b0;
  logic                     start = 1'b0;
  logic [WIDTH-1:0]         Q     = '0;
  logic [NCH*VW-1:0]        SW    = '0;
  logic                     busy;
  logic                     win_valid;
  logic [NCH-1:0]           win;
  logic [NCH*SCORE_W-1:0]   score;
  logic                     game_over;
  logic [NCH-1:0]           winner;

  typedef struct packed {
    logic [NCH-1:0]         win;
    logic [NCH*SCORE_W-1:0] score;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   model_score[NCH];

  cyber_player_array #(
    .WIDTH(WIDTH), .NCH(NCH), .SCORE_W(SCORE_W), .WIN_TARGET(WIN_TARGET)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .start(start), .Q(Q), .SW(SW),
    .busy(busy), .win_valid(win_valid), .win(win), .score(score),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NCH*SCORE_W-1:0] modelScore();
    logic [NCH*SCORE_W-1:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++) v[i*SCORE_W +: SCORE_W] = SCORE_W'(model_score[i]);
    return v;
  endfunction

  function automatic logic [NCH-1:0] modelWinner();
    logic [NCH-1:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++) v[i] = (model_score[i] == WIN_TARGET);
    return v;
  endfunction

  task automatic modelClear();
    for (int i = 0; i < NCH; i++) model_score[i] = 0;
    sb.delete();
  endtask

  // Drives one accepted start at the current negedge and queues the expected round outcome.
  task automatic applyStimulus(input logic [WIDTH-1:0] q, input logic [VW-1:0] s0, input logic [VW-1:0] s1);
    exp_t             e;
    logic [WIDTH-1:0] ext;
    logic             w;
    Q     = q;
    SW    = {s1, s0};
    start = 1'b1;
    e     = '0;
    for (int i = 0; i < NCH; i++) begin
      ext = {1'b0, (i == 0) ? s0 : s1};
`ifdef CYBER_TIE_WIN_EN
      w = (ext >= q);
`else
      w = (ext > q);
`endif
      e.win[i] = w;
      if (w && model_score[i] < WIN_TARGET) model_score[i]++;
    end
    e.score = modelScore();
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic awaitResult(input string tag);
    int   k;
    bit   seen;
    exp_t e;
    k    = 1;
    seen = 1'b0;
    while (k <= 8 && !seen) begin
      if (win_valid === 1'b1) seen = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    checkOutput({tag, "_valid_seen"}, 32'(seen), 32'd1);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    if (seen) begin
      checkOutput({tag, "_latency"}, 32'(k), 32'd3);
      checkOutput({tag, "_win"}, 32'(win), 32'(e.win));
      checkOutput({tag, "_score"}, 32'(score), 32'(e.score));
      checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    end
    @(negedge clk);
    checkOutput({tag, "_pulse_end"}, 32'(win_valid), 32'd0);
  endtask

  task automatic countPulses(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (win_valid === 1'b1) n++;
    end
  endtask

  initial begin
    int n;
    logic exp_tie;
    modelClear();

    // Reset state
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_win_valid", 32'(win_valid), 32'd0);
    checkOutput("rst_win", 32'(win), 32'd0);
    checkOutput("rst_score", 32'(score), 32'd0);
    checkOutput("rst_game_over", 32'(game_over), 32'd0);
    checkOutput("rst_winner", 32'(winner), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Basic round: only channel 0 above Q
    applyStimulus(10'd1, 9'd2, 9'd0);
    awaitResult("basic");
    checkOutput("basic_idle", 32'(busy), 32'd0);

    // Tie on channel 0, channel 1 strictly greater
    applyStimulus(10'd3, 9'd3, 9'd5);
    awaitResult("tie");
`ifdef CYBER_TIE_WIN_EN
    exp_tie = 1'b1;
`else
    exp_tie = 1'b0;
`endif
    checkOutput("tie_win0", 32'(win[0]), 32'(exp_tie));

    // Both channels win together
    applyStimulus(10'd0, 9'd4, 9'd9);
    awaitResult("both");

    // Inputs changed after start must not affect the round
    applyStimulus(10'd1, 9'd2, 9'd0);
    Q  = 10'd600;
    SW = '0;
    awaitResult("stable");
    checkOutput("stable_win0", 32'(win[0]), 32'd1);

    // Clear from IDLE
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    modelClear();
    checkOutput("clear_score", 32'(score), 32'd0);
    checkOutput("clear_win", 32'(win), 32'd0);

    // Clear and start in the same cycle: clear wins
    Q     = 10'd0;
    SW    = {9'd511, 9'd511};
    clear = 1'b1;
    start = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    start = 1'b0;
    checkOutput("clrstart_busy", 32'(busy), 32'd0);
    checkOutput("clrstart_score", 32'(score), 32'd0);
    countPulses(6, n);
    checkOutput("clrstart_no_pulse", 32'(n), 32'd0);

    // Reset one cycle after an accepted start
    Q     = 10'd0;
    SW    = {9'd0, 9'd511};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("midrst_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_score", 32'(score), 32'd0);
    checkOutput("midrst_win_valid", 32'(win_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    countPulses(6, n);
    checkOutput("midrst_no_pulse", 32'(n), 32'd0);
    checkOutput("midrst_score_after", 32'(score), 32'd0);
    modelClear();

    // Seven winning rounds end the game
    for (int r = 0; r < WIN_TARGET; r++) begin
      applyStimulus(10'd0, 9'd511, 9'd0);
      awaitResult("game_round");
    end
    checkOutput("over_game_over", 32'(game_over), 32'd1);
    checkOutput("over_winner", 32'(winner), 32'(modelWinner()));
    checkOutput("over_score", 32'(score), 32'(modelScore()));
    checkOutput("over_busy", 32'(busy), 32'd1);
    checkOutput("over_win_valid", 32'(win_valid), 32'd0);

    // An eighth start is ignored while the game is over
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    countPulses(6, n);
    checkOutput("over_start_ignored", 32'(n), 32'd0);
    checkOutput("over_busy_held", 32'(busy), 32'd1);
    checkOutput("over_score_held", 32'(score), 32'(modelScore()));

    // Clear leaves the game-over state
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    modelClear();
    checkOutput("newgame_over", 32'(game_over), 32'd0);
    checkOutput("newgame_winner", 32'(winner), 32'd0);
    checkOutput("newgame_busy", 32'(busy), 32'd0);

    // A fresh round works after the new game
    applyStimulus(10'd100, 9'd50, 9'd300);
    awaitResult("fresh");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
